// File: rtl/led_matrix_scan.sv
`default_nettype none
// ==== led_matrix_scan : row-multiplexed LED matrix driver with per-LED blink modes, ====
// ==== global PWM brightness and inter-row blanking                        -- rev 1.0 ====
module led_matrix_scan #(
  parameter int N_ROWS      = 4,
  parameter int N_COLS      = 4,
  parameter int ROW_TICKS   = 1024,
  parameter int BLANK_TICKS = 16,
  parameter int PWM_BITS    = 4,
  parameter int SLOW_DIV    = 23,
  parameter int FAST_DIV    = 21
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  enable,
  input  logic                                  wr_en,
  input  logic [$clog2(N_ROWS*N_COLS)-1:0]      wr_addr,
  input  logic [1:0]                            wr_data,
  input  logic [PWM_BITS-1:0]                   brightness,
  output logic [N_ROWS-1:0]                     aled,
  output logic [N_COLS-1:0]                     kled_oe,
  output logic                                  frame_start
);

  localparam int N_LEDS = N_ROWS * N_COLS;
  localparam int AW     = $clog2(N_LEDS);
  localparam int RW     = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int TMAX   = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] ROW_LAST   = TW'(ROW_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [RW-1:0] ROW_MAX    = RW'(N_ROWS - 1);
  localparam logic [AW:0]   N_LEDS_W   = (AW+1)'(N_LEDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [RW-1:0]   row, row_nx;
  logic [TW-1:0]   tick, tick_nx;
  logic [SLOW_DIV-1:0] blink_cnt;
  logic [1:0]      mode_ram [N_LEDS];

  // ---------------- scan sequencer ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      row   <= '0;
      tick  <= '0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      tick  <= tick_nx;
    end
  end

  always_comb begin
    state_nx = state;
    row_nx   = row;
    tick_nx  = tick;
    if (!enable) begin
      state_nx = IDLE;
      row_nx   = '0;
      tick_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = BLANK;
          row_nx   = '0;
          tick_nx  = '0;
        end
        BLANK: begin
          if (tick == BLANK_LAST) begin
            state_nx = ON;
            tick_nx  = '0;
          end else begin
            tick_nx = tick + TW'(1);
          end
        end
        ON: begin
          if (tick == ROW_LAST) begin
            state_nx = BLANK;
            tick_nx  = '0;
            row_nx   = (row == ROW_MAX) ? '0 : row + RW'(1);
          end else begin
            tick_nx = tick + TW'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          row_nx   = '0;
          tick_nx  = '0;
        end
      endcase
    end
  end

  // Blink timebase runs regardless of enable so blink phase is tied to reset only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + SLOW_DIV'(1);
    end
  end

  // ---------------- mode RAM ----------------
  logic wr_ok;
  assign wr_ok = wr_en && ({1'b0, wr_addr} < N_LEDS_W);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_LEDS; i++) begin
        mode_ram[i] <= 2'b00;
      end
    end else if (wr_ok) begin
      mode_ram[wr_addr] <= wr_data;
    end
  end

  // ---------------- column drive ----------------
  logic              blink_slow, blink_fast, pwm_on;
  logic [AW-1:0]     row_base;
  logic [N_COLS-1:0] lit;

  assign blink_slow = blink_cnt[SLOW_DIV-1];
  assign blink_fast = blink_cnt[FAST_DIV-1];
  assign pwm_on     = (brightness == {PWM_BITS{1'b1}}) ||
                      (tick[PWM_BITS-1:0] < brightness);
  assign row_base   = AW'(32'(row) * N_COLS);

  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    logic [1:0] mode;
    assign mode   = mode_ram[row_base + AW'(c)];
    assign lit[c] = pwm_on && ((mode == 2'b01) ||
                               ((mode == 2'b10) && blink_slow) ||
                               ((mode == 2'b11) && blink_fast));
  end

  // Output decode is gated by enable so a drop blanks the pads on the very next edge.
  logic [N_ROWS-1:0] aled_d;
  logic [N_COLS-1:0] kled_d;
  logic              frame_d;

  always_comb begin
    aled_d  = '0;
    kled_d  = '0;
    frame_d = 1'b0;
    if (enable) begin
      if ((state == BLANK) && (row == '0) && (tick == '0)) begin
        frame_d = 1'b1;
      end
      if (state == ON) begin
        aled_d[row] = 1'b1;
        kled_d      = lit;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aled        <= '0;
      kled_oe     <= '0;
      frame_start <= 1'b0;
    end else begin
      aled        <= aled_d;
      kled_oe     <= kled_d;
      frame_start <= frame_d;
    end
  end

endmodule
`default_nettype wire
